// File: rtl/branch_predictor.sv
// Bimodal branch predictor: a flop table of 2-bit saturating counters is read at fetch and
// trained at execute. The execute side also raises the mispredict flush and keeps branch statistics.
module branch_predictor #(
   parameter int         IDX_BITS   = 6,
   parameter logic [1:0] INIT_STATE = 2'b01
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic [31:0] PC_F,
   output logic        PredTaken_F,
   input  logic        Branch_E,
   input  logic        Stall_E,
   input  logic [31:0] PC_E,
   input  logic        PredTaken_E,
   input  logic        ComResult_E,
   input  logic [31:0] BranchTarget_E,
   input  logic [31:0] PCPlus4_E,
   output logic        Mispredict_E,
   output logic [31:0] RedirectPC_E,
   output logic [31:0] BranchCount,
   output logic [31:0] MispredictCount
);

   localparam int ENTRIES = 2 ** IDX_BITS;

   logic [1:0]          r_table [ENTRIES];
   logic [31:0]         r_branch_count;
   logic [31:0]         r_mispredict_count;

   logic [IDX_BITS-1:0] w_idx_f;
   logic [IDX_BITS-1:0] w_idx_e;
   logic                w_res;
   logic [1:0]          w_cur;
   logic [1:0]          w_upd;
   logic [ENTRIES-1:0]  w_we;
   logic                w_unused_bits;

   // Untagged direct index: PC bits above the index alias onto the same counter.
   assign w_idx_f = PC_F[IDX_BITS+1:2];
   assign w_idx_e = PC_E[IDX_BITS+1:2];
   assign w_unused_bits = ^{PC_F[31:IDX_BITS+2], PC_F[1:0], PC_E[31:IDX_BITS+2], PC_E[1:0]};

   assign w_res        = Branch_E & ~Stall_E;
   assign PredTaken_F  = r_table[w_idx_f][1];
   assign Mispredict_E = w_res & (ComResult_E ^ PredTaken_E);
   assign RedirectPC_E = ComResult_E ? BranchTarget_E : PCPlus4_E;

   assign BranchCount     = r_branch_count;
   assign MispredictCount = r_mispredict_count;

   always_comb begin
      w_cur = r_table[w_idx_e];
      w_upd = w_cur;
      if (ComResult_E) begin
         if (w_cur != 2'b11) w_upd = w_cur + 2'd1;
      end else begin
         if (w_cur != 2'b00) w_upd = w_cur - 2'd1;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < ENTRIES; gi++) begin : g_we
         assign w_we[gi] = w_res && (w_idx_e == IDX_BITS'(gi));
      end
   endgenerate

   // Reads see the pre-edge table, so a same-cycle fetch of the entry being trained gets the old value.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         for (int i = 0; i < ENTRIES; i++) r_table[i] <= INIT_STATE;
      end else begin
         for (int i = 0; i < ENTRIES; i++) begin
            if (w_we[i]) r_table[i] <= w_upd;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_branch_count     <= 32'd0;
         r_mispredict_count <= 32'd0;
      end else if (w_res) begin
         r_branch_count <= r_branch_count + 32'd1;
         if (Mispredict_E) r_mispredict_count <= r_mispredict_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: inputs change just after the falling edge,
// outputs are checked 1 ns later, state updates happen on the rising edge.
module tb_branch_predictor;

   logic        CLK = 1'b0;
   logic        Reset;
   logic [31:0] PC_F;
   logic        PredTaken_F;
   logic        Branch_E;
   logic        Stall_E;
   logic [31:0] PC_E;
   logic        PredTaken_E;
   logic        ComResult_E;
   logic [31:0] BranchTarget_E;
   logic [31:0] PCPlus4_E;
   logic        Mispredict_E;
   logic [31:0] RedirectPC_E;
   logic [31:0] BranchCount;
   logic [31:0] MispredictCount;

   int total = 0;
   int bad   = 0;

   always #5 CLK = ~CLK;

   branch_predictor #(.IDX_BITS(6), .INIT_STATE(2'b01)) dut (
      .CLK            (CLK),
      .Reset          (Reset),
      .PC_F           (PC_F),
      .PredTaken_F    (PredTaken_F),
      .Branch_E       (Branch_E),
      .Stall_E        (Stall_E),
      .PC_E           (PC_E),
      .PredTaken_E    (PredTaken_E),
      .ComResult_E    (ComResult_E),
      .BranchTarget_E (BranchTarget_E),
      .PCPlus4_E      (PCPlus4_E),
      .Mispredict_E   (Mispredict_E),
      .RedirectPC_E   (RedirectPC_E),
      .BranchCount    (BranchCount),
      .MispredictCount(MispredictCount)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
      $display("check %-22s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Advance one full cycle: across the rising edge to the next falling edge.
   task automatic cyc();
      @(negedge CLK);
   endtask

   initial begin
      Reset = 1'b0; PC_F = 32'h0; Branch_E = 1'b0; Stall_E = 1'b0; PC_E = 32'h0;
      PredTaken_E = 1'b0; ComResult_E = 1'b0; BranchTarget_E = 32'h200; PCPlus4_E = 32'h104;

      // Reset then idle
      @(negedge CLK); Reset = 1'b1;
      cyc(); Reset = 1'b0; PC_F = 32'h40; #1;
      chk("rst_pred", {31'd0, PredTaken_F}, 32'd0);
      chk("rst_bcnt", BranchCount, 32'd0);
      chk("rst_mcnt", MispredictCount, 32'd0);

      // Training to taken at 0x100: 01 -> 10 -> 11 -> 11
      PC_E = 32'h100; PC_F = 32'h100; Branch_E = 1'b1; ComResult_E = 1'b1; PredTaken_E = 1'b0; #1;
      chk("train1_misp", {31'd0, Mispredict_E}, 32'd1);
      chk("train1_pred_pre", {31'd0, PredTaken_F}, 32'd0);
      cyc(); #1;
      chk("train2_pred", {31'd0, PredTaken_F}, 32'd1);
      chk("train2_misp", {31'd0, Mispredict_E}, 32'd1);
      cyc(); PredTaken_E = 1'b1; #1;
      chk("train3_misp", {31'd0, Mispredict_E}, 32'd0);
      cyc(); Branch_E = 1'b0; #1;
      chk("train_bcnt", BranchCount, 32'd3);
      chk("train_mcnt", MispredictCount, 32'd2);
      chk("train_pred", {31'd0, PredTaken_F}, 32'd1);

      // No branch: mismatched outcome must not flag
      ComResult_E = 1'b0; PredTaken_E = 1'b1; #1;
      chk("nobr_misp", {31'd0, Mispredict_E}, 32'd0);

      // Redirect
      Branch_E = 1'b1; #1;
      chk("redir_nt_misp", {31'd0, Mispredict_E}, 32'd1);
      chk("redir_nt_pc", RedirectPC_E, 32'h104);
      ComResult_E = 1'b1; #1;
      chk("redir_t_pc", RedirectPC_E, 32'h200);
      chk("redir_t_misp", {31'd0, Mispredict_E}, 32'd0);
      cyc(); Branch_E = 1'b0; #1;
      chk("redir_bcnt", BranchCount, 32'd4);
      chk("redir_mcnt", MispredictCount, 32'd2);

      // Saturate low at index 1 (0x004), then one taken via alias 0x104 -> 01
      PC_E = 32'h4; PC_F = 32'h4; Branch_E = 1'b1; ComResult_E = 1'b0; PredTaken_E = 1'b0;
      cyc(); cyc(); cyc(); cyc();
      PC_E = 32'h104; ComResult_E = 1'b1; #1;
      chk("sat_pred_low", {31'd0, PredTaken_F}, 32'd0);
      chk("alias_misp", {31'd0, Mispredict_E}, 32'd1);
      cyc(); Branch_E = 1'b0; PC_F = 32'h104; #1;
      chk("alias_pred", {31'd0, PredTaken_F}, 32'd0);
      chk("sat_bcnt", BranchCount, 32'd9);
      chk("sat_mcnt", MispredictCount, 32'd3);

      // Stall holds everything
      PC_E = 32'h4; Branch_E = 1'b1; Stall_E = 1'b1; ComResult_E = 1'b1; PredTaken_E = 1'b0; #1;
      chk("stall_misp", {31'd0, Mispredict_E}, 32'd0);
      cyc(); #1;
      chk("stall_bcnt", BranchCount, 32'd9);
      chk("stall_mcnt", MispredictCount, 32'd3);

      // Collision: entry 01 -> 10 while fetching the same index
      Stall_E = 1'b0; PC_F = 32'h4; PredTaken_E = 1'b1; #1;
      chk("coll_pred_same", {31'd0, PredTaken_F}, 32'd0);
      cyc(); Branch_E = 1'b0; #1;
      chk("coll_pred_next", {31'd0, PredTaken_F}, 32'd1);
      chk("coll_bcnt", BranchCount, 32'd10);

      // Counter wrap
      force dut.r_branch_count = 32'hFFFF_FFFF;
      #1;
      chk("wrap_forced", BranchCount, 32'hFFFF_FFFF);
      release dut.r_branch_count;
      PC_E = 32'h200; Branch_E = 1'b1; ComResult_E = 1'b0; PredTaken_E = 1'b0;
      cyc(); Branch_E = 1'b0; #1;
      chk("wrap_bcnt", BranchCount, 32'd0);
      chk("wrap_mcnt", MispredictCount, 32'd3);

      // Reset wins over a same-cycle update
      PC_E = 32'h4; Branch_E = 1'b1; ComResult_E = 1'b1; PredTaken_E = 1'b0; Reset = 1'b1;
      cyc(); Reset = 1'b0; Branch_E = 1'b0; PC_F = 32'h4; #1;
      chk("rstp_pred_4", {31'd0, PredTaken_F}, 32'd0);
      chk("rstp_bcnt", BranchCount, 32'd0);
      chk("rstp_mcnt", MispredictCount, 32'd0);
      PC_F = 32'h100; #1;
      chk("rstp_pred_100", {31'd0, PredTaken_F}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch predictor and resolution unit for the 5-stage RISC-V core.
- Fetch side: reads a table of 2-bit saturating counters indexed by the fetch PC and returns a taken/not-taken prediction.
- Execute side: consumes the branch comparator's result (ComResult) for the resolving branch, detects a misprediction and supplies the corrective PC.
- Trains the counter table and keeps branch/mispredict performance counters.

Parameters:
- IDX_BITS, 6, index width; table holds 2**IDX_BITS counters.
- INIT_STATE, 2'b01, counter value loaded on reset (weakly not-taken).

Ports:
- CLK  input  1  clock, all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- PC_F  input  32  fetch-stage PC.
- PredTaken_F  output  1  prediction for PC_F (combinational).
- Branch_E  input  1  EX instruction is a conditional branch (valid).
- Stall_E  input  1  EX stage held; suppresses update and stats.
- PC_E  input  32  PC of the EX-stage branch.
- PredTaken_E  input  1  prediction that was issued for this branch, piped from F.
- ComResult_E  input  1  actual outcome from the comparator (1 = taken).
- BranchTarget_E  input  32  PC_E + imm.
- PCPlus4_E  input  32  PC_E + 4.
- Mispredict_E  output  1  flush request for F/D and redirect of fetch.
- RedirectPC_E  output  32  corrective fetch PC.
- BranchCount  output  32  resolved branches since reset.
- MispredictCount  output  32  mispredicted branches since reset.

Behaviour:
- Index: idx(x) = x[IDX_BITS+1:2]. PC bits [1:0] are ignored, and there is no tag, so aliasing is permitted.
- Prediction: PredTaken_F = table[idx(PC_F)][1]. This is a pure read with no latency.
- Resolve condition: res = Branch_E & ~Stall_E.
- Mispredict_E = res & (ComResult_E != PredTaken_E). It is combinational and 0 whenever res = 0.
- RedirectPC_E = ComResult_E ? BranchTarget_E : PCPlus4_E. It is always driven; consumers qualify it with Mispredict_E.
- Update: on a clock edge with res = 1, the entry table[idx(PC_E)] changes as follows.
  - Taken: increments, saturating at 2'b11.
  - Not-taken: decrements, saturating at 2'b00.
  - Only that one entry changes per cycle.
- State sequence: 00 SNT <-> 01 WNT <-> 10 WT <-> 11 ST.
  - Taken moves right; not-taken moves left.
  - Saturation holds at the ends.
- Read/write collision: if idx(PC_F) == idx(PC_E) in the same cycle as an update, PredTaken_F returns the pre-update value. There is no bypass.
- Statistics, on a clock edge with res = 1:
  - BranchCount += 1.
  - MispredictCount += 1 only if Mispredict_E.
  - Both are 32-bit and wrap from 0xFFFFFFFF to 0 with no saturation.
- Reset: on the rising edge with Reset = 1, all table entries load INIT_STATE, and BranchCount and MispredictCount load 0.
  - Reset takes priority over any same-cycle update.
  - After reset, PredTaken_F = INIT_STATE[1] = 0 for every PC.
  - A reset asserted mid-sequence discards all training.
- Stall_E = 1: there is no table or counter change, and Mispredict_E = 0. The branch resolves on the first cycle its EX stage is not stalled, so there is exactly one update per branch.
- Branch_E = 0 (non-branch, or bubble from a flush): no update. Jumps are resolved elsewhere and never reach this block as Branch_E.
- Outputs PredTaken_F, Mispredict_E and RedirectPC_E have no reset value; they follow their inputs combinationally. The only registered state is the counter table and the two statistics counters.
- Implementation: the table is a flop array (no RAM), so that reset is single-cycle.

Test Plan:
- Reset then idle: pulse Reset 1 cycle, PC_F = 0x00000040 -> PredTaken_F = 0; BranchCount = 0; MispredictCount = 0.
- Training to taken: PC_E = 0x00000100, Branch_E = 1, ComResult_E = 1, PredTaken_E = 0 for 3 cycles -> entry goes 01->10->11->11. Mispredict_E = 1 on cycles 1 and 2, 0 on cycle 3 once PredTaken_E = 1 is driven. PredTaken_F at PC_F = 0x100 = 1 after the first edge.
- Redirect: BranchTarget_E = 0x00000200, PCPlus4_E = 0x00000104, ComResult_E = 0, PredTaken_E = 1 -> Mispredict_E = 1, RedirectPC_E = 0x00000104; ComResult_E = 1 -> RedirectPC_E = 0x00000200.
- Saturation low plus aliasing: 4 not-taken updates at PC_E = 0x00000004 -> counter 00; then PC_F = 0x00000104 (IDX_BITS = 6, same index 1) -> PredTaken_F = 0.
- Stall and collision: Stall_E = 1 with Branch_E = 1 -> no counter or stat change, Mispredict_E = 0. Then an update while PC_F == PC_E, entry 01 to 10 -> PredTaken_F = 0 that cycle, 1 the next.
- Counter wrap and reset priority: force BranchCount to 0xFFFFFFFF, resolve one branch -> 0x00000000. Reset asserted together with Branch_E = 1 -> table = INIT_STATE, both counters 0.
